bus_seven_seg_ctrl: RTL and testbench



---
 rtl/bus_seven_seg_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bus_seven_seg_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_seven_seg_ctrl.sv
// Bus-mapped seven-segment controller: digit/DP/CTRL registers with readback
// and a multiplexed, active-low common-anode scan of up to 8 digits.
module bus_seven_seg_ctrl #(
    parameter logic [7:0] IO_ADDRESS  = 8'hD0,
    parameter int         NUM_DIGITS  = 4,
    parameter int         REFRESH_DIV = 100000,
    parameter int         BLINK_DIV   = 64
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  BUS_WE,
    input  logic [7:0]            ADDR,
    input  logic [7:0]            DATA_IN,
    output logic [7:0]            DATA_OUT,
    output logic                  DATA_OUT_VALID,
    output logic [NUM_DIGITS-1:0] SEG_SELECT_OUT,
    output logic [7:0]            HEX_OUT
);

    localparam int         NUM_BYTES = (NUM_DIGITS + 1) / 2;
    localparam int         RCNT_W    = $clog2(REFRESH_DIV);
    localparam int         FCNT_W    = $clog2(BLINK_DIV + 1);
    localparam logic [7:0] DP_MASK   = 8'((16'd1 << NUM_DIGITS) - 16'd1);

    // Hex font for g..a, active-low (a segment is lit when its bit is 0).
    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [7:0]        digit_r [4];
    logic [7:0]        dp_r;
    logic [1:0]        ctrl_r;
    logic [RCNT_W-1:0] refresh_cnt_r;
    logic [2:0]        index_r;
    logic [FCNT_W-1:0] frame_cnt_r;
    logic              blink_phase_r;

    logic [7:0]            offset_s;
    logic                  in_window_s;
    logic                  digit_mapped_s;
    logic [7:0]            rd_data_s;
    logic                  refresh_tc_s;
    logic                  index_wrap_s;
    logic                  frame_tc_s;
    logic                  blank_s;
    logic [7:0]            cur_byte_s;
    logic [3:0]            nibble_s;
    logic [NUM_DIGITS-1:0] sel_s;
    logic [7:0]            hex_s;

    assign offset_s       = ADDR - IO_ADDRESS;
    assign in_window_s    = offset_s < 8'd6;
    assign digit_mapped_s = offset_s < 8'(NUM_BYTES);
    assign refresh_tc_s   = refresh_cnt_r == RCNT_W'(REFRESH_DIV - 1);
    assign index_wrap_s   = refresh_tc_s && (index_r == 3'(NUM_DIGITS - 1));
    assign frame_tc_s     = frame_cnt_r == FCNT_W'(BLINK_DIV - 1);

    // Register file writes; unmapped offsets and unstored bits are dropped.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) digit_r[i] <= 8'h00;
            dp_r   <= 8'h00;
            ctrl_r <= 2'b01;
        end else if (BUS_WE && in_window_s) begin
            case (offset_s)
                8'd0, 8'd1, 8'd2, 8'd3: begin
                    if (digit_mapped_s) digit_r[offset_s[1:0]] <= DATA_IN;
                    else                digit_r[offset_s[1:0]] <= digit_r[offset_s[1:0]];
                end
                8'd4:    dp_r   <= DATA_IN & DP_MASK;
                8'd5:    ctrl_r <= DATA_IN[1:0];
                default: ctrl_r <= ctrl_r;
            endcase
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // Readback mux; unmapped window offsets read as zero.
    always_comb begin
        rd_data_s = 8'h00;
        case (offset_s)
            8'd0, 8'd1, 8'd2, 8'd3: begin
                if (digit_mapped_s) rd_data_s = digit_r[offset_s[1:0]];
                else                rd_data_s = 8'h00;
            end
            8'd4:    rd_data_s = dp_r;
            8'd5:    rd_data_s = {6'b000000, ctrl_r};
            default: rd_data_s = 8'h00;
        endcase
    end

    // Registered read response; DATA_OUT holds between reads.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            DATA_OUT       <= 8'h00;
            DATA_OUT_VALID <= 1'b0;
        end else if (!BUS_WE && in_window_s) begin
            DATA_OUT       <= rd_data_s;
            DATA_OUT_VALID <= 1'b1;
        end else begin
            DATA_OUT_VALID <= 1'b0;
        end
    end

    // Scan engine: refresh counter, digit index, frame counter and blink phase.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            refresh_cnt_r <= '0;
            index_r       <= 3'd0;
            frame_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (refresh_tc_s) begin
            refresh_cnt_r <= '0;
            if (index_wrap_s) begin
                index_r <= 3'd0;
                if (frame_tc_s) begin
                    frame_cnt_r   <= '0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
                end
            end else begin
                index_r <= index_r + 3'd1;
            end
        end else begin
            refresh_cnt_r <= refresh_cnt_r + RCNT_W'(1);
        end
    end

    // Pin values for the digit currently indexed, blanked by enable/blink.
    always_comb begin
        blank_s    = !ctrl_r[0] || (ctrl_r[1] && blink_phase_r);
        cur_byte_s = digit_r[index_r[2:1]];
        nibble_s   = index_r[0] ? cur_byte_s[7:4] : cur_byte_s[3:0];
        for (int k = 0; k < NUM_DIGITS; k++) begin
            sel_s[k] = blank_s || (index_r != 3'(k));
        end
        if (blank_s) hex_s = 8'hFF;
        else         hex_s = {~dp_r[index_r], seg_font(nibble_s)};
    end

    // Anodes and segments update on the same edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            SEG_SELECT_OUT <= {NUM_DIGITS{1'b1}};
            HEX_OUT        <= 8'hFF;
        end else begin
            SEG_SELECT_OUT <= sel_s;
            HEX_OUT        <= hex_s;
        end
    end

endmodule

// File: tb/tb_bus_seven_seg_ctrl.sv
// Bench for bus_seven_seg_ctrl: three instances (4, 8 and 1 digits) on a shared
// bus, checked every cycle against a frame/phase arithmetic model plus literals.
module tb_bus_seven_seg_ctrl;

    localparam int RDIV = 4;
    localparam int BDIV = 2;
    localparam int NI   = 3;
    localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic       CLK = 1'b0;
    logic       RESET;
    logic       BUS_WE = 1'b0;
    logic [7:0] ADDR = 8'h00;
    logic [7:0] DATA_IN = 8'h00;

    logic [7:0] dout0, dout1, dout2;
    logic       val0, val1, val2;
    logic [3:0] sel0;
    logic [7:0] sel1;
    logic [0:0] sel2;
    logic [7:0] hex0, hex1, hex2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    bus_seven_seg_ctrl #(.IO_ADDRESS(8'hD0), .NUM_DIGITS(4), .REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) u_d4 (
        .CLK(CLK), .RESET(RESET), .BUS_WE(BUS_WE), .ADDR(ADDR), .DATA_IN(DATA_IN),
        .DATA_OUT(dout0), .DATA_OUT_VALID(val0), .SEG_SELECT_OUT(sel0), .HEX_OUT(hex0));
    bus_seven_seg_ctrl #(.IO_ADDRESS(8'hD0), .NUM_DIGITS(8), .REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) u_d8 (
        .CLK(CLK), .RESET(RESET), .BUS_WE(BUS_WE), .ADDR(ADDR), .DATA_IN(DATA_IN),
        .DATA_OUT(dout1), .DATA_OUT_VALID(val1), .SEG_SELECT_OUT(sel1), .HEX_OUT(hex1));
    bus_seven_seg_ctrl #(.IO_ADDRESS(8'hD0), .NUM_DIGITS(1), .REFRESH_DIV(RDIV), .BLINK_DIV(BDIV)) u_d1 (
        .CLK(CLK), .RESET(RESET), .BUS_WE(BUS_WE), .ADDR(ADDR), .DATA_IN(DATA_IN),
        .DATA_OUT(dout2), .DATA_OUT_VALID(val2), .SEG_SELECT_OUT(sel2), .HEX_OUT(hex2));

    function automatic int nd(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 8 : 1);
    endfunction

    function automatic logic [7:0] ones(input int n);
        return 8'((16'd1 << n) - 16'd1);
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0] m_reg [NI][6];
    logic [7:0] m_sel [NI];
    logic [7:0] m_hex [NI];
    logic [7:0] m_dout [NI];
    logic       m_valid [NI];
    int         m_ecount;
    wire  [7:0] bus_off = ADDR - 8'hD0;

    function automatic logic is_blank(input int i, input int k);
        int frame;
        int phase;
        frame = k / (RDIV * nd(i));
        phase = (frame / BDIV) % 2;
        return !m_reg[i][5][0] || (m_reg[i][5][1] && phase == 1);
    endfunction

    function automatic logic [7:0] exp_sel(input int i, input int k);
        int idx;
        idx = (k / RDIV) % nd(i);
        if (is_blank(i, k)) return ones(nd(i));
        return ones(nd(i)) & ~(8'd1 << idx);
    endfunction

    function automatic logic [7:0] exp_hex(input int i, input int k);
        int idx;
        logic [7:0] byt;
        logic [3:0] nib;
        logic [7:0] h;
        idx = (k / RDIV) % nd(i);
        if (is_blank(i, k)) return 8'hFF;
        byt = m_reg[i][idx / 2];
        nib = (idx % 2 == 1) ? byt[7:4] : byt[3:0];
        h = FONT[nib];
        if (m_reg[i][4][idx]) h[7] = 1'b0;
        return h;
    endfunction

    function automatic logic [7:0] rd_value(input int i, input logic [7:0] off);
        if (off < 8'd4 && int'(off) >= (nd(i) + 1) / 2) return 8'h00;
        return m_reg[i][off];
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_ecount <= 0;
            for (int i = 0; i < NI; i++) begin
                for (int r = 0; r < 6; r++) m_reg[i][r] <= (r == 5) ? 8'h01 : 8'h00;
                m_sel[i]   <= ones(nd(i));
                m_hex[i]   <= 8'hFF;
                m_dout[i]  <= 8'h00;
                m_valid[i] <= 1'b0;
            end
        end else begin
            m_ecount <= m_ecount + 1;
            for (int i = 0; i < NI; i++) begin
                m_sel[i] <= exp_sel(i, m_ecount);
                m_hex[i] <= exp_hex(i, m_ecount);
                if (BUS_WE && bus_off < 8'd6) begin
                    if (bus_off < 8'd4) begin
                        if (int'(bus_off) < (nd(i) + 1) / 2) m_reg[i][bus_off] <= DATA_IN;
                    end else if (bus_off == 8'd4) begin
                        m_reg[i][4] <= DATA_IN & ones(nd(i));
                    end else begin
                        m_reg[i][5] <= DATA_IN & 8'h03;
                    end
                end
                if (!BUS_WE && bus_off < 8'd6) begin
                    m_valid[i] <= 1'b1;
                    m_dout[i]  <= rd_value(i, bus_off);
                end else begin
                    m_valid[i] <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(negedge CLK) begin
        check("d4_sel", {4'h0, sel0}, m_sel[0]);
        check("d4_hex", hex0, m_hex[0]);
        check("d4_valid", {7'h00, val0}, {7'h00, m_valid[0]});
        check("d4_dout", dout0, m_dout[0]);
        check("d8_sel", sel1, m_sel[1]);
        check("d8_hex", hex1, m_hex[1]);
        check("d8_valid", {7'h00, val1}, {7'h00, m_valid[1]});
        check("d8_dout", dout1, m_dout[1]);
        check("d1_sel", {7'h00, sel2}, m_sel[2]);
        check("d1_hex", hex2, m_hex[2]);
        check("d1_valid", {7'h00, val2}, {7'h00, m_valid[2]});
        check("d1_dout", dout2, m_dout[2]);
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        BUS_WE = 1'b1; ADDR = a; DATA_IN = d;
        @(negedge CLK);
        BUS_WE = 1'b0; ADDR = 8'h00; DATA_IN = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d0, output logic [7:0] d1,
                            output logic [7:0] d2);
        BUS_WE = 1'b0; ADDR = a;
        @(negedge CLK);
        ADDR = 8'h00;
        d0 = dout0; d1 = dout1; d2 = dout2;
    endtask

    task automatic sync_to(input int modulus, input int rem);
        int guard;
        guard = 0;
        while ((m_ecount % modulus) != rem && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 200) check("sync_timeout", 8'd1, 8'd0);
    endtask

    logic [7:0] r0, r1, r2;
    logic [3:0] scan_sel [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] scan_hex [4] = '{8'h79, 8'h24, 8'h30, 8'h19};
    int blanks;

    initial begin
        RESET = 1'b1;
        #1 RESET = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_sel", {4'h0, sel0}, 8'h0F);
        check("rst_hex", hex0, 8'hFF);
        check("rst_valid", {7'h00, val0}, 8'h00);
        RESET = 1'b1;

        bus_read(8'hD5, r0, r1, r2); check("rst_ctrl", r0, 8'h01);
        bus_read(8'hD0, r0, r1, r2); check("rst_dig0", r0, 8'h00);

        bus_write(8'hD0, 8'h21);
        bus_write(8'hD1, 8'h43);
        bus_write(8'hD4, 8'hFF);
        bus_write(8'hD5, 8'hFF);
        bus_read(8'hD0, r0, r1, r2); check("rb_d0", r0, 8'h21); check("rb_d0_n1", r2, 8'h21);
        bus_read(8'hD1, r0, r1, r2); check("rb_d1", r0, 8'h43); check("rb_d1_n1", r2, 8'h00);
        bus_read(8'hD4, r0, r1, r2);
        check("rb_dp", r0, 8'h0F); check("rb_dp_n8", r1, 8'hFF); check("rb_dp_n1", r2, 8'h01);
        bus_read(8'hD5, r0, r1, r2); check("rb_ctrl", r0, 8'h03);

        bus_read(8'hD2, r0, r1, r2); check("rb_unmapped", r0, 8'h00);
        bus_write(8'hD2, 8'h55);
        bus_read(8'hD0, r0, r1, r2); check("unmapped_wr_d0", r0, 8'h21);
        bus_read(8'hD1, r0, r1, r2); check("unmapped_wr_d1", r0, 8'h43);
        bus_read(8'hD2, r0, r1, r2); check("unmapped_wr_d2", r0, 8'h00);
        bus_write(8'hD3, 8'h7C);
        bus_write(8'hD5, 8'h01);

        // Scan order over one frame plus the wrap back to digit 0.
        sync_to(16, 0);
        for (int j = 0; j < 16; j++) begin
            @(negedge CLK);
            check("scan_sel", {4'h0, sel0}, {4'h0, scan_sel[j / 4]});
            check("scan_hex", hex0, scan_hex[j / 4]);
        end
        @(negedge CLK);
        check("scan_wrap", {4'h0, sel0}, 8'h0E);

        sync_to(32, 29);
        check("d8_digit7_sel", sel1, 8'h7F);
        check("d8_digit7_hex", hex1, 8'h78);
        check("d1_sel", {7'h00, sel2}, 8'h00);
        check("d1_hex", hex2, 8'h79);

        bus_write(8'hD5, 8'h03);
        sync_to(64, 0);
        blanks = 0;
        for (int j = 0; j < 32; j++) begin
            @(negedge CLK);
            if (sel0 == 4'hF && hex0 == 8'hFF) blanks++;
        end
        check("blink_lit_phase", 8'(blanks), 8'd0);
        blanks = 0;
        for (int j = 0; j < 32; j++) begin
            @(negedge CLK);
            if (sel0 == 4'hF && hex0 == 8'hFF) blanks++;
        end
        check("blink_dark_phase", 8'(blanks), 8'd32);

        bus_write(8'hD5, 8'h01);
        bus_write(8'hD5, 8'h00);
        @(negedge CLK);
        check("disable_sel", {4'h0, sel0}, 8'h0F);
        check("disable_hex", hex0, 8'hFF);

        bus_write(8'hD5, 8'h01);
        sync_to(16, 9);
        check("pre_rst_sel", {4'h0, sel0}, 8'h0B);
        check("pre_rst_hex", hex0, 8'h30);
        #2 RESET = 1'b0;
        #1;
        check("async_rst_sel", {4'h0, sel0}, 8'h0F);
        check("async_rst_hex", hex0, 8'hFF);
        check("async_rst_valid", {7'h00, val0}, 8'h00);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check("post_rst_sel", {4'h0, sel0}, 8'h0E);
        bus_read(8'hD5, r0, r1, r2); check("post_rst_ctrl", r0, 8'h01);
        bus_read(8'hD0, r0, r1, r2); check("post_rst_d0", r0, 8'h00);
        bus_read(8'hD4, r0, r1, r2); check("post_rst_dp", r0, 8'h00);

        repeat (4) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
